// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle datapath.
// Holds the FSM state type, pc_sel codes, ALU op codes (FS[4:2]) and the
// control-word field offsets, expressed as functions of the register
// address width RW so that every file decodes the word identically.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    WB       = 2'd3
  } state_t;

  // pc_sel codes
  localparam logic [1:0] PC_INC4 = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_BRZ  = 2'b10;
  localparam logic [1:0] PC_ABS  = 2'b11;

  // ALU op codes carried in FS[4:2]; any other code passes B through
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  // Control word, MSB first:
  // {FS[4:0], Cin, AA, AB, DA, w, ram_write, en_alu, en_ram, b_sel, pc_sel[1:0]}
  localparam int OFF_PC_SEL    = 0;
  localparam int OFF_B_SEL     = 2;
  localparam int OFF_EN_RAM    = 3;
  localparam int OFF_EN_ALU    = 4;
  localparam int OFF_RAM_WRITE = 5;
  localparam int OFF_W         = 6;

  function automatic int cw_width(input int rw);
    return 13 + 3 * rw;
  endfunction

  function automatic int off_da(input int rw);
    return 7 + 0 * rw;
  endfunction

  function automatic int off_ab(input int rw);
    return 7 + rw;
  endfunction

  function automatic int off_aa(input int rw);
    return 7 + 2 * rw;
  endfunction

  function automatic int off_cin(input int rw);
    return 7 + 3 * rw;
  endfunction

  function automatic int off_fs(input int rw);
    return 8 + 3 * rw;
  endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file: REG_CNT words of DATA_W bits.
// Ports: clk/reset (async, active-high, clears all words), two asynchronous
// read ports (ra/rda, rb/rdb) and one synchronous write port (we/wa/wd).
// The highest register is hard-wired to zero: it reads 0 and ignores writes.
module regfile_p #(
  parameter int  DATA_W  = 64,
  parameter int  REG_CNT = 32,
  localparam int RW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RW-1:0]     ra,
  output logic [DATA_W-1:0] rda,
  input  logic [RW-1:0]     rb,
  output logic [DATA_W-1:0] rdb,
  input  logic              we,
  input  logic [RW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  localparam logic [RW-1:0] ZERO_REG = RW'(REG_CNT - 1);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Write port with asynchronous clear; the zero register is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we && (wa != ZERO_REG)) begin
      regs[wa] <= wd;
    end
  end

  assign rda = (ra == ZERO_REG) ? '0 : regs[ra];
  assign rdb = (rb == ZERO_REG) ? '0 : regs[rb];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: IDLE -> EXEC -> [MEM_WAIT] -> WB -> IDLE.
// Ports: clk, reset (async active-high); cw_valid/cw_ready handshake for
// control_word and constant k; done pulses during WB; status {V,C,N,Z};
// pc program counter; err sticky bus-conflict flag.
module datapath_mc
  import dp_pkg::*;
#(
  parameter int  DATA_W  = 64,
  parameter int  REG_CNT = 32,
  parameter int  RAM_AW  = 13,
  parameter int  RAM_LAT = 2,
  localparam int RW      = $clog2(REG_CNT),
  localparam int CW_W    = cw_width(RW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [CW_W-1:0]   control_word,
  input  logic [DATA_W-1:0] k,
  output logic              done,
  output logic [3:0]        status,
  output logic [DATA_W-1:0] pc,
  output logic              err
);

  state_t            state;
  logic [CW_W-1:0]   cw;
  logic [DATA_W-1:0] k_lat;
  logic [DATA_W-1:0] f_lat;
  logic [DATA_W-1:0] bus;
  logic              conflict;
  logic [2:0]        cnt;

  logic [DATA_W-1:0] ram     [2**RAM_AW];
  logic [DATA_W-1:0] rd_pipe [RAM_LAT];

  // Fields of the latched control word
  logic [4:0]    fs;
  logic          cin, w, ram_write, en_alu, en_ram, b_sel;
  logic [RW-1:0] aa, ab, da;
  logic [1:0]    pc_sel;

  assign fs        = cw[off_fs(RW) +: 5];
  assign cin       = cw[off_cin(RW)];
  assign aa        = cw[off_aa(RW) +: RW];
  assign ab        = cw[off_ab(RW) +: RW];
  assign da        = cw[off_da(RW) +: RW];
  assign w         = cw[OFF_W];
  assign ram_write = cw[OFF_RAM_WRITE];
  assign en_alu    = cw[OFF_EN_ALU];
  assign en_ram    = cw[OFF_EN_RAM];
  assign b_sel     = cw[OFF_B_SEL];
  assign pc_sel    = cw[OFF_PC_SEL +: 2];

  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rf_we;

  // Write-back happens on the WB exit edge; a conflicting word never writes
  assign rf_we = (state == WB) && w && !conflict;

  regfile_p #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra    (aa),
    .rda   (rf_a),
    .rb    (ab),
    .rdb   (rf_b),
    .we    (rf_we),
    .wa    (da),
    .wd    (bus)
  );

  logic [DATA_W-1:0] a_op, b_op, f;
  logic [DATA_W:0]   sum;
  logic              is_add, alu_c, alu_v;

  assign a_op   = rf_a ^ {DATA_W{fs[1]}};
  assign b_op   = (b_sel ? k_lat : rf_b) ^ {DATA_W{fs[0]}};
  assign sum    = {1'b0, a_op} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
  assign is_add = (fs[4:2] == OP_ADD);
  assign alu_c  = is_add & sum[DATA_W];
  // Overflow: both operands share a sign that the result does not
  assign alu_v  = is_add & (a_op[DATA_W-1] == b_op[DATA_W-1])
                         & (sum[DATA_W-1] != a_op[DATA_W-1]);

  // ALU result selection
  always_comb begin
    f = '0;
    case (fs[4:2])
      OP_AND:  f = a_op & b_op;
      OP_OR:   f = a_op | b_op;
      OP_ADD:  f = sum[DATA_W-1:0];
      OP_XOR:  f = a_op ^ b_op;
      OP_SHL:  f = a_op << b_op[5:0];
      OP_SHR:  f = a_op >> b_op[5:0];
      default: f = b_op;
    endcase
  end

  logic [DATA_W-1:0] pc_next;

  // Next program counter; branch tests Z as already updated by this word
  always_comb begin
    pc_next = pc + DATA_W'(3'd4);
    case (pc_sel)
      PC_INC4: pc_next = pc + DATA_W'(3'd4);
      PC_REL:  pc_next = pc + k_lat;
      PC_BRZ:  pc_next = status[0] ? (pc + k_lat) : (pc + DATA_W'(3'd4));
      PC_ABS:  pc_next = f_lat;
      default: pc_next = pc + DATA_W'(3'd4);
    endcase
  end

  // RAM write port: store R[AB] at the EXEC exit edge, independent of b_sel
  always_ff @(posedge clk) begin
    if ((state == EXEC) && ram_write) ram[f[RAM_AW-1:0]] <= rf_b;
  end

  // Read pipeline: stage 0 captures the word addressed at EXEC exit, and the
  // last stage holds it RAM_LAT edges after that
  always_ff @(posedge clk) begin
    rd_pipe[0] <= ram[f[RAM_AW-1:0]];
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cw       <= '0;
      k_lat    <= '0;
      f_lat    <= '0;
      bus      <= '0;
      conflict <= 1'b0;
      cnt      <= 3'd0;
      status   <= 4'd0;
      err      <= 1'b0;
      done     <= 1'b0;
      pc       <= '0;
      cw_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cw_valid) begin
            cw       <= control_word;
            k_lat    <= k;
            cw_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          f_lat    <= f;
          conflict <= en_alu & en_ram;
          cnt      <= 3'(RAM_LAT - 1);
          if (en_alu) status <= {alu_v, alu_c, f[DATA_W-1], (f == '0)};
          if (en_alu && en_ram) err <= 1'b1;
          if (en_ram && !en_alu) begin
            state <= MEM_WAIT;
          end else begin
            bus   <= en_alu ? f : '0;
            done  <= 1'b1;
            state <= WB;
          end
        end
        MEM_WAIT: begin
          if (cnt == 3'd0) begin
            bus   <= rd_pipe[RAM_LAT-1];
            done  <= 1'b1;
            state <= WB;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WB: begin
          done     <= 1'b0;
          pc       <= pc_next;
          cw_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          cw_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Self-checking bench for datapath_mc (RAM_LAT=3, RAM_AW=5).
// The driver runs each word through an array-based reference model and
// pushes the expected response; a monitor pops on every done pulse.
// Register contents are observed by read-back words that copy R[AB] to pc.
module tb_datapath_mc;

  localparam int DW = 64;
  localparam int RL = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cw_valid;
  logic          cw_ready;
  logic [27:0]   control_word;
  logic [DW-1:0] k;
  logic          done;
  logic [3:0]    status;
  logic [DW-1:0] pc;
  logic          err;

  datapath_mc #(.DATA_W(DW), .REG_CNT(32), .RAM_AW(AW), .RAM_LAT(RL)) dut (
    .clk          (clk),
    .reset        (reset),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .control_word (control_word),
    .k            (k),
    .done         (done),
    .status       (status),
    .pc           (pc),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            cyc;
    logic [3:0]    st;
    logic          er;
    logic [DW-1:0] pc_old;
    logic [DW-1:0] pc_new;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [DW-1:0] m_reg [32];
  logic [DW-1:0] m_ram [2**AW];
  logic [DW-1:0] m_pc;
  logic [3:0]    m_status;
  logic          m_err;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0; m_status = 4'd0; m_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] rd(input logic [4:0] r);
    return (r == 5'd31) ? '0 : m_reg[r];
  endfunction

  // Apply one word to the model; returns whether it takes the memory path
  task automatic model_step(input logic [4:0] fs, input logic cin,
                            input logic [4:0] aa, ab, da,
                            input logic w, rw, ea, er, bs,
                            input logic [1:0] ps, input logic [DW-1:0] kk,
                            output bit is_mem);
    logic [DW-1:0] a, b, f, busv;
    logic [DW:0]   usum;
    logic signed [DW+1:0] ssum, smax, smin;
    logic c, v, confl;
    a = rd(aa);
    b = bs ? kk : rd(ab);
    if (fs[1]) a = ~a;
    if (fs[0]) b = ~b;
    c = 1'b0; v = 1'b0;
    case (fs[4:2])
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: begin
        usum = (DW+1)'(a) + (DW+1)'(b) + (DW+1)'(cin);
        f = usum[DW-1:0];
        c = (usum > (DW+1)'({DW{1'b1}}));
        smax = (66'sd1 <<< 63) - 66'sd1;
        smin = -(66'sd1 <<< 63);
        ssum = $signed({a[DW-1], a}) + $signed({b[DW-1], b}) + $signed({65'd0, cin});
        v = (ssum > smax) || (ssum < smin);
      end
      3'd3: f = a ^ b;
      3'd4: f = a << b[5:0];
      3'd5: f = a >> b[5:0];
      default: f = b;
    endcase
    if (ea) m_status = {v, c, f[DW-1], f == '0};
    confl = ea & er;
    if (confl) m_err = 1'b1;
    is_mem = er & ~ea;
    busv = ea ? f : (er ? m_ram[f[AW-1:0]] : '0);
    if (rw) m_ram[f[AW-1:0]] = rd(ab);
    if (w && !confl && da != 5'd31) m_reg[da] = busv;
    case (ps)
      2'd0: m_pc = m_pc + 64'd4;
      2'd1: m_pc = m_pc + kk;
      2'd2: m_pc = m_status[0] ? m_pc + kk : m_pc + 64'd4;
      default: m_pc = f;
    endcase
  endtask

  // Offer one word; optionally model/check it and hold cw_valid into EXEC
  task automatic issue(input logic [4:0] fs, input logic cin,
                       input logic [4:0] aa, ab, da,
                       input logic w, rw, ea, er, bs,
                       input logic [1:0] ps, input logic [DW-1:0] kk,
                       input bit check_it, input bit hold);
    int n = 0;
    exp_t e;
    bit is_mem;
    @(negedge clk);
    while (cw_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL ready_timeout: cw_ready stuck at %0b, required 1", cw_ready);
      return;
    end
    control_word = {fs, cin, aa, ab, da, w, rw, ea, er, bs, ps};
    k = kk;
    cw_valid = 1'b1;
    if (check_it) begin
      e.pc_old = m_pc;
      model_step(fs, cin, aa, ab, da, w, rw, ea, er, bs, ps, kk, is_mem);
      // accept edge makes cyc = cyc+1; done is seen one cycle later, plus RL on loads
      e.cyc = cyc + 2 + (is_mem ? RL : 0);
      e.st = m_status; e.er = m_err; e.pc_new = m_pc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (hold) begin
      control_word = {5'b11000, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
      k = 64'h1234;
      @(negedge clk);
    end
    cw_valid = 1'b0;
  endtask

  // Read-back word: pc <= R[r], status <= {0,0,N,Z} of R[r]
  task automatic readback(input logic [4:0] r);
    issue(5'b11000, 1'b0, 5'd0, r, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 64'd0, 1'b1, 1'b0);
  endtask

  // Load constant into register via pass-B
  task automatic setreg(input logic [4:0] r, input logic [DW-1:0] v);
    issue(5'b11000, 1'b0, 5'd0, 5'd0, r, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, v, 1'b1, 1'b0);
  endtask

  // Monitor: pops one expectation per done pulse; pc is checked after WB exit
  initial begin
    exp_t e;
    bit pc_pend = 1'b0;
    logic [DW-1:0] pc_exp = '0;
    forever begin
      @(negedge clk);
      if (pc_pend) begin
        chk("pc_after_wb", pc, pc_exp);
        pc_pend = 1'b0;
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("status", 64'(status), 64'(e.st));
          chk("err", 64'(err), 64'(e.er));
          chk("pc_in_wb", pc, e.pc_old);
          pc_exp = e.pc_new;
          pc_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    logic [4:0] fs, aa, ab, da;
    logic [1:0] ps;
    logic cin, w, rw, ea, er, bs;
    logic [DW-1:0] kk;

    reset = 1'b1; cw_valid = 1'b0; control_word = '0; k = '0;
    model_reset();
    for (int i = 0; i < 2**AW; i++) m_ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cw_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    // ADD R3 = R1 + R2
    setreg(5'd1, 64'd5);
    setreg(5'd2, 64'd7);
    issue(5'b01000, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 1'b0);
    readback(5'd3);

    // SUB R4 = R1 - k (k=5): Z=1, C=1; then branch on Z with k=0x40
    issue(5'b01001, 1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 64'd5, 1'b1, 1'b0);
    issue(5'b00000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 64'h40, 1'b1, 1'b0);
    readback(5'd4);

    // Store R2=0xAA at 0x10, load into R5
    setreg(5'd2, 64'hAA);
    issue(5'b11000, 1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 64'h10, 1'b1, 1'b0);
    issue(5'b11000, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 64'h10, 1'b1, 1'b0);
    readback(5'd5);

    // Write to the zero register with cw_valid held through EXEC
    issue(5'b11000, 1'b0, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 64'hFF, 1'b1, 1'b1);
    readback(5'd31);
    readback(5'd7);

    // Bus conflict: R6 untouched, err sticky
    setreg(5'd6, 64'h66);
    issue(5'b11000, 1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 64'h99, 1'b1, 1'b0);
    readback(5'd6);

    // Reset during MEM_WAIT aborts the load
    issue(5'b11000, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 64'h10, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_ready", 64'(cw_ready), 64'd1);
    chk("abort_pc", pc, 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    readback(5'd5);

    // Randomised registers, RAM fill, then random words
    for (int i = 0; i < 31; i++) setreg(5'(i), {$urandom, $urandom});
    for (int i = 0; i < 2**AW; i++)
      issue(5'b11000, 1'b0, 5'd0, 5'($urandom_range(0, 31)), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
            2'b00, 64'(i), 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      fs = 5'($urandom); cin = 1'($urandom); aa = 5'($urandom); ab = 5'($urandom);
      da = 5'($urandom); w = 1'($urandom); rw = 1'($urandom); ea = 1'($urandom);
      er = 1'($urandom); bs = 1'($urandom); ps = 2'($urandom);
      kk = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
      if (er && !ea) rw = 1'b0;
      issue(fs, cin, aa, ab, da, w, rw, ea, er, bs, ps, kk, 1'b1, 1'b0);
    end
    for (int i = 0; i < 32; i++) readback(5'(i));

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameter DATA_W, default 64: datapath word width.
REQ-002 Parameter REG_CNT, default 32: register count, power of 2; RW = log2(REG_CNT).
REQ-003 Parameter RAM_AW, default 13: RAM word-address width; depth 2^RAM_AW.
REQ-004 Parameter RAM_LAT, default 2, range 1..4: RAM read latency in cycles.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 cw_valid  in  1  control word offered.
REQ-008 cw_ready  out  1  block idle, can accept a control word.
REQ-009 control_word  in  13+3*RW  {FS[4:0], Cin, AA, AB, DA, w, ram_write, en_alu, en_ram, b_sel, pc_sel[1:0]}, MSB first.
REQ-010 k  in  DATA_W  constant operand, sampled at accept.
REQ-011 done  out  1  one-cycle pulse in the WB state.
REQ-012 status  out  4  {V,C,N,Z}, latched from the last ALU-enabled word.
REQ-013 pc  out  DATA_W  program counter.
REQ-014 err  out  1  sticky bus-conflict flag.

Function
REQ-015 FSM states: IDLE, EXEC, MEM_WAIT, WB; cw_ready SHALL be 1 only in IDLE.
REQ-016 Accept: cw_valid&cw_ready at edge t latches control_word and k; state becomes EXEC at t.
REQ-017 EXEC: A = R[AA]; B = b_sel ? k : R[AB]; F = ALU(A,B); next state is MEM_WAIT if en_ram&~en_alu, else WB.
REQ-018 ALU: FS[1] inverts A, FS[0] inverts B; FS[4:2] selects 000 AND, 001 OR, 010 A+B+Cin, 011 XOR, 100 A<<B[5:0], 101 A>>B[5:0] logical, others B.
REQ-019 Status: Z = (F==0), N = F[DATA_W-1], C = adder carry-out, V = signed overflow; C and V are 0 for non-add ops; status updates at EXEC exit only when en_alu=1.
REQ-020 ram_write=1: RAM[F[RAM_AW-1:0]] <= R[AB] at EXEC exit, regardless of b_sel.
REQ-021 MEM_WAIT: the word at address F[RAM_AW-1:0] is presented exactly RAM_LAT cycles after EXEC; a counter holds MEM_WAIT for RAM_LAT cycles, then WB.
REQ-022 Data bus value: en_alu only -> F; en_ram only -> RAM word; neither -> 0; both -> conflict.
REQ-023 WB: done=1; if w=1 and no conflict, R[DA] <= bus at WB exit; WB always returns to IDLE.
REQ-024 Register REG_CNT-1 SHALL read 0, and writes to it SHALL be ignored.
REQ-025 pc_sel at WB: 00 pc+4; 01 pc+k; 10 Z(updated) ? pc+k : pc+4; 11 F; all arithmetic is mod 2^DATA_W.
REQ-026 Conflict (en_alu&en_ram): err set at EXEC exit; FSM goes to WB with no register write; status updates normally; pc update per pc_sel.
REQ-027 Latency: non-memory word: done at t+2; memory read: done at t+2+RAM_LAT.
REQ-028 cw_valid outside IDLE SHALL be ignored, with no queueing.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, pc=0, status=0, err=0, done=0, all registers 0, and the latched control word to 0; RAM contents are not reset.
REQ-030 Reset in any state SHALL abort the operation with no register, RAM, or pc update.

Structure
REQ-031 Package dp_pkg SHALL hold the FSM state enum, pc_sel codes, FS op codes, and control-word field offsets as functions of RW.
REQ-032 The register file SHALL be sub-module regfile_p (params DATA_W, REG_CNT; 2 async read ports, 1 sync write port, async reset).

Verification
REQ-033 R1=5, R2=7, word ADD (FS=01000, Cin=0) AA=1, AB=2, DA=3, w=1, en_alu=1 -> done at t+2, R3=12, status=0000, pc=4.
REQ-034 R1=5, SUB (FS=01001, Cin=1) with b_sel=1, k=5, DA=4 -> R4=0, Z=1, C=1; then pc_sel=10 with k=0x40 -> pc=0x44.
REQ-035 RAM_LAT=3: store R2=0xAA at address 0x10, then load to R5 -> load done at t+5, R5=0xAA.
REQ-036 en_alu=en_ram=1, w=1, DA=6 -> err=1, R6 unchanged, done pulses, err stays 1 until reset.
REQ-037 Assert reset during MEM_WAIT -> immediate IDLE, cw_ready=1, pc=0, destination register 0.
REQ-038 DA=REG_CNT-1 write of 0xFF -> subsequent read of that register returns 0; cw_valid held in EXEC -> no second accept.
